fifo_traffic_sched: RTL and testbench

//  Rate-controlled traffic scheduler for the Zybo Z7 async-FIFO demo. Generates slow write/read

---
 rtl/fifo_sched_pkg.sv | 25 ++
 rtl/rate_tick_gen.sv | 22 ++
 rtl/fifo_traffic_sched.sv | 140 ++++++++++++++
 tb/tb_fifo_traffic_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO traffic scheduler.
package fifo_sched_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned DROP_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    STREAM = 2'd3
  } sched_state_t;

  localparam logic MODE_BURST  = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  // Saturating add of a 0..2 increment onto the drop counter.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [1:0]        inc);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(inc);
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Single-clock rate divider: one-cycle tick every DIV cycles while enabled, held at 0 otherwise.
module rate_tick_gen #(
  parameter int unsigned DIV   = 10,
  parameter int unsigned CNT_W = 24
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100MHz) begin
    if (reset || !en)                   cnt <= '0;
    else if (cnt == CNT_W'(DIV - 1))    cnt <= '0;
    else                                cnt <= cnt + CNT_W'(1);
  end

  assign tick = en && (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/fifo_traffic_sched.sv
// Rate-controlled burst/stream traffic scheduler driving async-FIFO wr_en/rd_en.
// Optional blocked-tick counter enabled by defining FIFO_SCHED_DROP_CNT_EN.
module fifo_traffic_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned WR_DIV    = 10_000_000,
  parameter int unsigned RD_DIV    = 4_000_000,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               wr_full,
  input  logic               rd_empty,
  output logic               wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic               rd_en,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_o,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);

  sched_state_t       state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               wr_en_d, rd_en_d, done_d;
  logic               wr_tick, rd_tick;
  logic               wr_tick_en, rd_tick_en;

  assign wr_tick_en = (state_q == FILL)  || (state_q == STREAM);
  assign rd_tick_en = (state_q == DRAIN) || (state_q == STREAM);

  rate_tick_gen #(.DIV(WR_DIV), .CNT_W(CNT_W)) u_wr_tick (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (wr_tick_en),
    .tick       (wr_tick)
  );

  rate_tick_gen #(.DIV(RD_DIV), .CNT_W(CNT_W)) u_rd_tick (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (rd_tick_en),
    .tick       (rd_tick)
  );

  // Next state and strobe requests; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          burst_d = '0;
          state_d = (mode == MODE_STREAM) ? STREAM : FILL;
        end
      end
      FILL: begin
        if (wr_tick) begin
          if (wr_full) begin
            state_d = DRAIN;
          end else begin
            wr_en_d = 1'b1;
            burst_d = burst_q + BURST_W'(1);
            if (burst_q == BURST_W'(BURST_LEN - 1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_tick) begin
          if (rd_empty) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_en_d = 1'b1;
          end
        end
      end
      STREAM: begin
        wr_en_d = wr_tick && !wr_full;
        rd_en_d = rd_tick && !rd_empty;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && stop) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      done    <= 1'b0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      wr_en   <= wr_en_d;
      rd_en   <= rd_en_d;
      done    <= done_d;
      if (wr_en) wr_data <= wr_data + DATA_W'(1);
    end
  end

  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

`ifdef FIFO_SCHED_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q;
  logic [1:0]        drop_inc;

  assign drop_inc = {1'b0, (state_q == STREAM) && wr_tick && wr_full}
                  + {1'b0, (state_q == STREAM) && rd_tick && rd_empty};

  always_ff @(posedge clk_100MHz) begin
    if (reset) drop_q <= '0;
    else       drop_q <= sat_add(drop_q, drop_inc);
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_traffic_sched.sv
// Directed self-checking bench for fifo_traffic_sched (WR_DIV=4, RD_DIV=10, BURST_LEN=4).
module tb_fifo_traffic_sched;

  logic        clk_100MHz = 1'b0;
  logic        reset, start, stop, mode, wr_full, rd_empty;
  logic        wr_en, rd_en, busy, done;
  logic [7:0]  wr_data;
  logic [1:0]  state_o;
  logic [15:0] drop_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_data = 8'd0;

  always #5 clk_100MHz = ~clk_100MHz;

  fifo_traffic_sched #(
    .WR_DIV(4), .RD_DIV(10), .CNT_W(24), .DATA_W(8), .BURST_LEN(4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .wr_full    (wr_full),
    .rd_empty   (rd_empty),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .busy       (busy),
    .done       (done),
    .state_o    (state_o),
    .drop_cnt   (drop_cnt)
  );

  task automatic cyc();
    @(negedge clk_100MHz);
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1 with start dropped.
  task automatic start_run(input logic m);
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    wr_full = 1'b0; rd_empty = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({wr_en, rd_en, done, busy, state_o, wr_data, drop_cnt} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_hold got wr=%b rd=%b done=%b busy=%b st=%0d data=%h drop=%h exp all 0",
               wr_en, rd_en, done, busy, state_o, wr_data, drop_cnt);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if ({wr_en, rd_en, done, busy, state_o} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release got wr=%b rd=%b done=%b busy=%b st=%0d exp all 0",
               wr_en, rd_en, done, busy, state_o);
    end
  endtask

  task automatic test_burst();
    wr_full = 1'b0; rd_empty = 1'b0;
    start_run(1'b0);
    for (int c = 1; c <= 48; c++) begin
      logic       ew, er, ed;
      logic [1:0] es;
      ew = (c == 5) || (c == 9) || (c == 13) || (c == 17);
      er = (c == 27) || (c == 37);
      ed = (c == 47);
      es = (c <= 16) ? 2'd1 : (c <= 46) ? 2'd2 : 2'd0;
      n_checks++;
      if ({wr_en, rd_en, done, state_o, busy} !== {ew, er, ed, es, es != 2'd0}) begin
        n_fail++;
        $display("FAIL burst c=%0d got wr=%b rd=%b done=%b st=%0d busy=%b exp wr=%b rd=%b done=%b st=%0d",
                 c, wr_en, rd_en, done, state_o, busy, ew, er, ed, es);
      end
      if (ew) begin
        n_checks++;
        if (wr_data !== exp_data) begin
          n_fail++;
          $display("FAIL burst_data c=%0d got %h exp %h", c, wr_data, exp_data);
        end
        exp_data++;
      end
      if (c == 40) rd_empty = 1'b1;
      cyc();
    end
  endtask

  task automatic test_full_abort();
    wr_full = 1'b0; rd_empty = 1'b1;
    start_run(1'b0);
    for (int c = 1; c <= 21; c++) begin
      logic       ew, ed;
      logic [1:0] es;
      ew = (c == 5);
      ed = (c == 19);
      es = (c <= 8) ? 2'd1 : (c <= 18) ? 2'd2 : 2'd0;
      n_checks++;
      if ({wr_en, rd_en, done, state_o} !== {ew, 1'b0, ed, es}) begin
        n_fail++;
        $display("FAIL full_abort c=%0d got wr=%b rd=%b done=%b st=%0d exp wr=%b rd=0 done=%b st=%0d",
                 c, wr_en, rd_en, done, state_o, ew, ed, es);
      end
      if (ew) begin
        n_checks++;
        if (wr_data !== exp_data) begin
          n_fail++;
          $display("FAIL full_abort_data got %h exp %h", wr_data, exp_data);
        end
        exp_data++;
      end
      if (c == 6) wr_full = 1'b1;
      cyc();
    end
    wr_full = 1'b0;
  endtask

  task automatic test_stream_stop();
    wr_full = 1'b0; rd_empty = 1'b0;
    start_run(1'b1);
    for (int c = 1; c <= 46; c++) begin
      logic       ew, er;
      logic [1:0] es;
      ew = (c >= 5) && (c <= 37) && ((c - 1) % 4 == 0);
      er = (c == 11) || (c == 21) || (c == 31);
      es = (c <= 40) ? 2'd3 : 2'd0;
      n_checks++;
      if ({wr_en, rd_en, done, state_o} !== {ew, er, 1'b0, es}) begin
        n_fail++;
        $display("FAIL stream_stop c=%0d got wr=%b rd=%b done=%b st=%0d exp wr=%b rd=%b done=0 st=%0d",
                 c, wr_en, rd_en, done, state_o, ew, er, es);
      end
      if (ew) begin
        n_checks++;
        if (wr_data !== exp_data) begin
          n_fail++;
          $display("FAIL stream_data c=%0d got %h exp %h", c, wr_data, exp_data);
        end
        exp_data++;
      end
      if (c == 40) stop = 1'b1;
      if (c == 42) stop = 1'b0;
      cyc();
    end
  endtask

  // Two stream runs of 123 writes each bring the total to 260 writes.
  task automatic test_wrap();
    wr_full = 1'b0; rd_empty = 1'b1;
    for (int run = 0; run < 2; run++) begin
      start_run(1'b1);
      for (int c = 1; c <= 4 * 123 + 2; c++) begin
        logic ew;
        ew = (c >= 5) && (c <= 4 * 123 + 1) && ((c - 1) % 4 == 0);
        n_checks++;
        if ({wr_en, rd_en} !== {ew, 1'b0}) begin
          n_fail++;
          $display("FAIL wrap_strobe run=%0d c=%0d got wr=%b rd=%b exp wr=%b rd=0",
                   run, c, wr_en, rd_en, ew);
        end
        if (ew) begin
          n_checks++;
          if (wr_data !== exp_data) begin
            n_fail++;
            $display("FAIL wrap_data run=%0d c=%0d got %h exp %h", run, c, wr_data, exp_data);
          end
          exp_data++;
        end
        if (c == 4 * 123 + 1) stop = 1'b1;
        if (c == 4 * 123 + 2) begin
          n_checks++;
          if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_stop_state got %0d exp 0", state_o);
          end
          stop = 1'b0;
        end
        cyc();
      end
    end
    n_checks++;
    if (wr_data !== 8'h04) begin
      n_fail++;
      $display("FAIL wrap_final got %h exp 04", wr_data);
    end
  endtask

  task automatic test_reset_mid_stream();
    wr_full = 1'b0; rd_empty = 1'b0;
    start_run(1'b1);
    repeat (11) cyc();
    reset = 1'b1;
    for (int c = 13; c <= 18; c++) begin
      cyc();
      n_checks++;
      if ({wr_en, rd_en, done, busy, state_o, wr_data, drop_cnt} !== 30'd0) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d got wr=%b rd=%b done=%b busy=%b st=%0d data=%h drop=%h exp all 0",
                 c, wr_en, rd_en, done, busy, state_o, wr_data, drop_cnt);
      end
      if (c == 15) reset = 1'b0;
    end
    exp_data = 8'd0;
  endtask

  task automatic test_drops();
    int acc;
    wr_full = 1'b1; rd_empty = 1'b1;
    acc = 0;
    start_run(1'b1);
    for (int c = 1; c <= 23; c++) begin
`ifdef FIFO_SCHED_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 16'(acc)) begin
        n_fail++;
        $display("FAIL drops c=%0d got %0d exp %0d", c, drop_cnt, acc);
      end
      acc += ((c % 4 == 0) ? 1 : 0) + ((c % 10 == 0) ? 1 : 0);
`else
      n_checks++;
      if (drop_cnt !== 16'h0000) begin
        n_fail++;
        $display("FAIL drops_off c=%0d got %h exp 0000", c, drop_cnt);
      end
`endif
      n_checks++;
      if ({wr_en, rd_en} !== 2'b00) begin
        n_fail++;
        $display("FAIL drops_strobe c=%0d got wr=%b rd=%b exp 0", c, wr_en, rd_en);
      end
      if (c == 22) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
`ifdef FIFO_SCHED_DROP_CNT_EN
    force dut.drop_q = 16'hFFFC;
    cyc();
    release dut.drop_q;
    cyc();
    acc = 32'h0000FFFC;
    start_run(1'b1);
    for (int c = 1; c <= 14; c++) begin
      n_checks++;
      if (drop_cnt !== 16'(acc)) begin
        n_fail++;
        $display("FAIL drops_sat c=%0d got %h exp %h", c, drop_cnt, 16'(acc));
      end
      acc += ((c % 4 == 0) ? 1 : 0) + ((c % 10 == 0) ? 1 : 0);
      if (acc > 32'h0000FFFF) acc = 32'h0000FFFF;
      if (c == 13) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_burst();
    test_full_abort();
    test_stream_stop();
    test_wrap();
    test_reset_mid_stream();
    test_drops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
